instruction_buffer: RTL and testbench
=====================================

// Module: instruction_buffer
// PURPOSE
//  Circular FIFO between fetch/decode and dispatch. Each cycle it accepts up to 4 pre-decoded
//  entries (opcode, rt/ra/rb, local-dependency owners, unit class flags) and presents the 4
//  oldest to dispatch. num_free drives the fetch stage's num_fetch input (fetch width).
//  A taken branch (flush) discards all buffered entries.
// PARAMETERS
//  DEPTH    16  entries; power of 2, >=4
//  ENTRY_W  30  entry bits {opcode[29:26],rt[25:22],ra[21:18],rb[17:14],a_dep[13],a_own[12:9],
//               b_dep[8],b_own[7:4],uses_rb[3],is_ld_str[2],is_fxu[1],is_branch[0]}
// PORTS
//  clk        in   1          clock, all state updates on posedge
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          decode lanes carry real instructions this cycle
//  in_count   in   3          number of valid decode lanes, 0..4; lanes 0..in_count-1, lane 0 oldest
//  in_entry   in   4*ENTRY_W  lane i = in_entry[i*ENTRY_W +: ENTRY_W]
//  flush      in   1          taken jump: discard everything
//  deq_count  in   3          entries dispatch consumes this cycle, 0..4, from lane 0 upward
//  out_valid  out  4          lane mask; bit i = (count > i)
//  out_entry  out  4*ENTRY_W  lane i = entry at (head+i) mod DEPTH; content is don't-care when invalid
//  num_free   out  3          min(DEPTH-count, 4)
//  count      out  5          occupancy 0..DEPTH ($clog2(DEPTH)+1 bits)
//  err        out  1          sticky protocol-violation flag
// BEHAVIOUR
//  - State: storage[DEPTH], head, tail ($clog2(DEPTH) bits, wrap mod DEPTH), count, err.
//  - Reset: head=tail=count=0, err=0 -> out_valid=0, num_free=4, count=0. Storage is not cleared.
//  - Outputs: combinational from registered state only; no input-to-output combinational path.
//  - Effective enqueue: enq = in_valid ? min(in_count, free) : 0, where free = DEPTH-count before
//    this edge.
//  - Effective dequeue: deq = min(deq_count, count) before this edge.
//  - Space freed by a dequeue is not reusable by an enqueue in the same cycle.
//  - Normal edge: write lanes 0..enq-1 to storage[(tail+i) mod DEPTH]; then
//    tail+=enq, head+=deq, count += enq-deq.
//  - Latency: an entry written at edge N is visible on out_* in the cycle after edge N.
//    Empty-buffer bypass does not exist.
//  - Ordering: strict program order; out lane 0 is always the oldest entry.
//  - Flush (priority over everything): head=tail=count=0 next cycle.
//    Same-cycle enqueue and dequeue are dropped; err is unchanged.
//  - err set (sticky until rst) when any of:
//    - in_valid && in_count > free
//    - deq_count > count
//    - in_count > 4 or deq_count > 4
//    The transaction is still clamped as above.
//  - Full (count==DEPTH): num_free=0; any in_valid with in_count>0 sets err and writes nothing.
//  - Empty (count==0): out_valid=0; any deq_count>0 sets err and changes no state.
//  - rst asserted mid-stream: behaves exactly as reset, regardless of flush/enq/deq.
// TESTING
//  1 Reset, then idle -> out_valid=0000, num_free=4, count=0, err=0.
//  2 Enqueue 4 entries with opcodes 1,2,3,4 (in_count=4), deq=0 -> next cycle out_valid=1111,
//    lane order 1,2,3,4, count=4.
//  3 Fill to 16 (4 x in_count=4), then in_count=4 -> count=16, num_free=0, no write, err=1.
//  4 Wrap: from count=14, head=10 -> deq=3 and enq=2 together -> count=13, tail wraps 8->10,
//    lanes show oldest-first across index 15->0.
//  5 Flush with count=9, enq=4, deq=2 same cycle -> next cycle count=0, out_valid=0, num_free=4.
//  6 Empty buffer, deq_count=2 -> state unchanged, err=1; then rst -> err=0.

Source files
------------

// File: rtl/instruction_buffer_if.sv
// Handshake bundle between decode/fetch, the instruction buffer and dispatch.
// master drives the decode and dispatch requests; slave is the buffer itself.
interface instruction_buffer_if #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 30
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   in_valid;
    logic [2:0]             in_count;
    logic [4*ENTRY_W-1:0]   in_entry;
    logic                   flush;
    logic [2:0]             deq_count;
    logic [3:0]             out_valid;
    logic [4*ENTRY_W-1:0]   out_entry;
    logic [2:0]             num_free;
    logic [CNT_W-1:0]       count;
    logic                   err;

    modport master (
        output in_valid, in_count, in_entry, flush, deq_count,
        input  out_valid, out_entry, num_free, count, err
    );

    modport slave (
        input  in_valid, in_count, in_entry, flush, deq_count,
        output out_valid, out_entry, num_free, count, err
    );
endinterface

// File: rtl/instruction_buffer.sv
// Circular 4-in/4-out instruction FIFO between decode and dispatch.
// Outputs depend only on registered state; a flush empties the buffer.
module instruction_buffer #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    instruction_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LANES = 4;

    logic [ENTRY_W-1:0] storage [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             err_reg, err_next;

    logic [CNT_W-1:0] free;
    logic [CNT_W-1:0] enq;
    logic [CNT_W-1:0] deq;
    logic             violation;

    logic [LANES-1:0] wr_en;
    logic [PTR_W-1:0] wr_addr [LANES];
    logic [PTR_W-1:0] rd_addr [LANES];

    always_comb begin
        free = CNT_W'(DEPTH) - count_reg;

        // Clamp requests to what the buffer can actually take or give.
        enq = '0;
        if (bus.in_valid) begin
            enq = CNT_W'(bus.in_count);
            if (enq > free)
                enq = free;
            if (enq > CNT_W'(LANES))
                enq = CNT_W'(LANES);
        end

        deq = CNT_W'(bus.deq_count);
        if (deq > count_reg)
            deq = count_reg;
        if (deq > CNT_W'(LANES))
            deq = CNT_W'(LANES);

        violation = (bus.in_valid && (CNT_W'(bus.in_count) > free))
                  || (CNT_W'(bus.deq_count) > count_reg)
                  || (bus.in_count > 3'd4)
                  || (bus.deq_count > 3'd4);

        if (bus.flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
            err_next   = err_reg;
        end else begin
            head_next  = head_reg + PTR_W'(deq);
            tail_next  = tail_reg + PTR_W'(enq);
            count_next = count_reg + enq - deq;
            err_next   = err_reg | violation;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign wr_en[gi]   = !rst && !bus.flush && (CNT_W'(gi) < enq);
            assign wr_addr[gi] = tail_reg + PTR_W'(gi);
            assign rd_addr[gi] = head_reg + PTR_W'(gi);

            assign bus.out_valid[gi] = (count_reg > CNT_W'(gi));
            assign bus.out_entry[gi*ENTRY_W +: ENTRY_W] = storage[rd_addr[gi]];
        end
    endgenerate

    // Storage carries no reset; stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i])
                storage[wr_addr[i]] <= bus.in_entry[i*ENTRY_W +: ENTRY_W];
        end
    end

    assign bus.num_free = (free > CNT_W'(LANES)) ? 3'd4 : free[2:0];
    assign bus.count    = count_reg;
    assign bus.err      = err_reg;
endmodule

// File: tb/tb_instruction_buffer.sv
// Bench for instruction_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_instruction_buffer;
    localparam int DEPTH = 16;
    localparam int EW    = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_buffer_if #(.DEPTH(DEPTH), .ENTRY_W(EW)) bus ();

    instruction_buffer #(.DEPTH(DEPTH), .ENTRY_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] model_q[$];
    bit            model_err = 1'b0;
    bit            checking  = 1'b0;
    int            seq_no    = 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [EW-1:0] lane_out(int i);
        return bus.out_entry[i*EW +: EW];
    endfunction

    // One clock: drive, let the edge happen, then advance the model by the same rules.
    task automatic apply(bit r, bit v, int cnt, bit fl, int dq);
        logic [EW-1:0] lanes [4];
        int free, enq, deq;
        for (int i = 0; i < 4; i++) begin
            lanes[i] = EW'(seq_no + i) | (EW'($urandom_range(0, 1023)) << 20);
            bus.in_entry[i*EW +: EW] = lanes[i];
        end
        rst           = r;
        bus.in_valid  = v;
        bus.in_count  = 3'(cnt);
        bus.flush     = fl;
        bus.deq_count = 3'(dq);
        @(posedge clk);
        #1;
        if (r) begin
            model_q.delete();
            model_err = 1'b0;
        end else if (fl) begin
            model_q.delete();
        end else begin
            free = DEPTH - model_q.size();
            if ((v && cnt > free) || dq > model_q.size() || cnt > 4 || dq > 4)
                model_err = 1'b1;
            enq = v ? ((cnt < free) ? cnt : free) : 0;
            deq = (dq < model_q.size()) ? dq : model_q.size();
            for (int i = 0; i < deq; i++) void'(model_q.pop_front());
            for (int i = 0; i < enq; i++) model_q.push_back(lanes[i]);
            seq_no += enq;
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            int sz;
            sz = model_q.size();
            check("count", 64'(bus.count), 64'(sz));
            check("num_free", 64'(bus.num_free), 64'(((DEPTH - sz) < 4) ? (DEPTH - sz) : 4));
            check("err", 64'(bus.err), 64'(model_err));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("out_valid[%0d]", i), 64'(bus.out_valid[i]), 64'(sz > i));
                if (i < sz)
                    check($sformatf("lane%0d", i), 64'(lane_out(i)), 64'(model_q[i]));
            end
        end
    end

    initial begin
        int base;
        int r, fl, v, cnt, dq, sz;
        bus.in_valid  = 1'b0;
        bus.in_count  = 3'd0;
        bus.in_entry  = '0;
        bus.flush     = 1'b0;
        bus.deq_count = 3'd0;

        apply(1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0);
        checking = 1'b1;

        // Reset then idle
        apply(0, 0, 0, 0, 0);
        check("t1_out_valid", 64'(bus.out_valid), 64'h0);
        check("t1_num_free", 64'(bus.num_free), 64'd4);
        check("t1_count", 64'(bus.count), 64'd0);
        check("t1_err", 64'(bus.err), 64'd0);

        // Four entries tagged 1..4 appear oldest-first
        apply(0, 1, 4, 0, 0);
        check("t2_out_valid", 64'(bus.out_valid), 64'hf);
        check("t2_count", 64'(bus.count), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_lane%0d", i), 64'(lane_out(i) & 30'hFFFFF), 64'(i + 1));

        // Fill to 16, then an extra batch is rejected and flagged
        apply(0, 1, 4, 0, 0);
        apply(0, 1, 4, 0, 0);
        apply(0, 1, 4, 0, 0);
        check("t3_count_full", 64'(bus.count), 64'd16);
        check("t3_num_free_full", 64'(bus.num_free), 64'd0);
        check("t3_err_before", 64'(bus.err), 64'd0);
        apply(0, 1, 4, 0, 0);
        check("t3_count_after", 64'(bus.count), 64'd16);
        check("t3_err_after", 64'(bus.err), 64'd1);
        check("t3_lane0_kept", 64'(lane_out(0) & 30'hFFFFF), 64'd1);

        apply(1, 0, 0, 0, 0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);

        // Wrap: reach head=10 with count=14, then deq 3 + enq 2
        base = seq_no;
        apply(0, 1, 4, 0, 0);
        apply(0, 1, 4, 0, 0);
        apply(0, 1, 4, 0, 0);
        apply(0, 0, 0, 0, 4);
        apply(0, 0, 0, 0, 4);
        apply(0, 0, 0, 0, 2);
        apply(0, 1, 4, 0, 0);
        apply(0, 1, 4, 0, 0);
        apply(0, 1, 4, 0, 0);
        check("t4_count14", 64'(bus.count), 64'd14);
        check("t4_lane0_before", 64'(lane_out(0) & 30'hFFFFF), 64'(base + 10));
        apply(0, 1, 2, 0, 3);
        check("t4_count13", 64'(bus.count), 64'd13);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_lane%0d", i), 64'(lane_out(i) & 30'hFFFFF), 64'(base + 13 + i));
        check("t4_err", 64'(bus.err), 64'd0);

        // Flush wins over same-cycle enqueue and dequeue
        apply(0, 0, 0, 0, 4);
        check("t5_count9", 64'(bus.count), 64'd9);
        apply(0, 1, 4, 1, 2);
        check("t5_count", 64'(bus.count), 64'd0);
        check("t5_out_valid", 64'(bus.out_valid), 64'h0);
        check("t5_num_free", 64'(bus.num_free), 64'd4);
        check("t5_err", 64'(bus.err), 64'd0);

        // Dequeue from empty
        apply(0, 0, 0, 0, 2);
        check("t6_count", 64'(bus.count), 64'd0);
        check("t6_err", 64'(bus.err), 64'd1);
        apply(1, 0, 0, 0, 0);
        check("t6_err_rst", 64'(bus.err), 64'd0);

        // Randomized run; over-range counts only where clamping is unambiguous
        for (int n = 0; n < 3000; n++) begin
            sz  = model_q.size();
            r   = ($urandom_range(0, 199) == 0);
            fl  = ($urandom_range(0, 31) == 0);
            v   = ($urandom_range(0, 3) != 0);
            if ((DEPTH - sz) <= 4 && $urandom_range(0, 9) == 0)
                cnt = $urandom_range(5, 7);
            else
                cnt = $urandom_range(0, 4);
            if (sz <= 4 && $urandom_range(0, 9) == 0)
                dq = $urandom_range(5, 7);
            else
                dq = $urandom_range(0, 4);
            apply(r[0], v[0], cnt, fl[0], dq);
        end

        @(negedge clk);
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
